// File: rtl/seq_pkg.sv
// Types shared by the serializer and the sequence detector that consumes its output.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAPW  = 2'd2
    } seq_state_e;

    // Width of a bit-count field able to hold 0..width inclusive.
    function automatic int seq_lw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_serializer.sv
// MSB-first word serializer with optional idle gap between words.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0,
    parameter int LW    = seq_lw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    output logic             a,
    output logic             a_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [WIDTH-1:0] r_sh;
    logic [LW-1:0]    r_bits;
    logic [GW-1:0]    r_gap;
    logic             r_rdy_en;

    logic [LW-1:0]    w_len;
    logic [LW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_aligned;
    logic             w_accept;
    logic             w_start;
    logic             w_last;

    // Left-align the word so the first bit to send sits in the MSB.
    assign w_len     = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
    assign w_shamt   = LW'(WIDTH) - w_len;
    assign w_aligned = in_data << w_shamt;

    assign w_last    = (r_state == SHIFT) && (r_bits == LW'(1));
    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && (w_len != '0);

    // The shift register is zeroed outside SHIFT, so a reads 0 whenever a_valid is low.
    assign a = r_sh[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    if (GAP > 0) begin
                        w_next = GAPW;
                    end else if (w_start) begin
                        w_next = SHIFT;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            GAPW: begin
                if (r_gap <= GW'(1)) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        a_valid   = 1'b0;
        word_done = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = r_rdy_en;
            end
            SHIFT: begin
                a_valid   = 1'b1;
                word_done = w_last;
                in_ready  = r_rdy_en && (GAP == 0) && w_last;
                busy      = 1'b1;
            end
            GAPW: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // r_rdy_en holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh     <= '0;
            r_bits   <= '0;
            r_gap    <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_start) begin
                r_sh   <= w_aligned;
                r_bits <= w_len;
            end else if (w_last) begin
                r_sh   <= '0;
                r_bits <= '0;
            end else if (r_state == SHIFT) begin
                r_sh   <= r_sh << 1;
                r_bits <= r_bits - LW'(1);
            end

            if (w_last && (GAP > 0)) begin
                r_gap <= GW'(GAP);
            end else if ((r_state == GAPW) && (r_gap != '0)) begin
                r_gap <= r_gap - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized bench for seq_serializer (GAP=0 and GAP=2 instances) against a slot-queue model.
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] in_len;
    logic       rdy0, a0, av0, wd0, bz0;
    logic       rdy1, a1, av1, wd1, bz1;

    int n_checks = 0;
    int n_errors = 0;

    // Model slots: 1 = bit 0, 2 = bit 1, +4 = last bit of word, 8 = gap cycle, 0 = idle.
    int q0[$];
    int q1[$];
    int cur0, cur1;
    bit st;
    bit mr0, mr1;

    logic [31:0] h0, h1, v1;
    int c0, zc;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .GAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_len(in_len), .a(a0), .a_valid(av0),
        .word_done(wd0), .busy(bz0)
    );

    seq_serializer #(.WIDTH(8), .GAP(2)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_len(in_len), .a(a1), .a_valid(av1),
        .word_done(wd1), .busy(bz1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int cur, input int qs, input int gap, input bit started);
        return started && ((cur == 0) || ((gap == 0) && ((cur & 4) != 0) && (qs == 0)));
    endfunction

    task automatic m_adv(inout int q[$], inout int cur, input int gap, input bit rdy,
                         input logic v, input logic [7:0] d, input logic [3:0] l);
        int n;
        if (rdy && v) begin
            n = (l > 8) ? 8 : int'(l);
            if (n > 0) begin
                for (int i = n - 1; i >= 0; i--) q.push_back((d[i] ? 2 : 1) | ((i == 0) ? 4 : 0));
                for (int k = 0; k < gap; k++) q.push_back(8);
            end
        end
        cur = (q.size() > 0) ? q.pop_front() : 0;
    endtask

    task automatic check_all();
        mr0 = m_ready(cur0, q0.size(), 0, st);
        mr1 = m_ready(cur1, q1.size(), 2, st);
        check_val("out0", {rdy0, av0, a0, wd0, bz0},
                  {mr0, (cur0 & 3) != 0, (cur0 & 3) == 2, (cur0 & 4) != 0, cur0 != 0});
        check_val("out1", {rdy1, av1, a1, wd1, bz1},
                  {mr1, (cur1 & 3) != 0, (cur1 & 3) == 2, (cur1 & 4) != 0, cur1 != 0});
        if (av0) begin
            h0 = {h0[30:0], a0};
            c0++;
        end
        if (av1) h1 = {h1[30:0], a1};
        v1 = {v1[30:0], av1};
        if (av0 || wd0 || av1 || wd1) zc++;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input logic [3:0] l);
        in_valid = v;
        in_data  = d;
        in_len   = l;
        check_all();
        @(posedge clk);
        if (reset) begin
            m_adv(q0, cur0, 0, mr0, v, d, l);
            m_adv(q1, cur1, 2, mr1, v, d, l);
            st = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        cur0 = 0;
        cur1 = 0;
        st   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_len = '0;
        model_reset();
        h0 = '0; h1 = '0; v1 = '0; c0 = 0; zc = 0;
        @(negedge clk);
        step(1'b1, 8'hFF, 4'd8);
        step(1'b0, 8'h00, 4'd0);
        reset = 1'b1;
        step(1'b0, 8'h00, 4'd0);
        step(1'b0, 8'h00, 4'd0);

        // Single 3-bit word 101.
        h0 = '0;
        step(1'b1, 8'h05, 4'd3);
        repeat (4) step(1'b0, 8'h00, 4'd0);
        check_val("w101_bits", h0[2:0], 3'b101);

        // Back-to-back words on the GAP=0 instance.
        h0 = '0; c0 = 0;
        repeat (4) step(1'b1, 8'h05, 4'd3);
        repeat (8) step(1'b0, 8'h00, 4'd0);
        check_val("b2b_bits", h0[5:0], 6'b101101);
        check_val("b2b_cnt", c0, 6);

        // Gap of two on the GAP=2 instance, next word pending.
        h1 = '0; v1 = '0;
        step(1'b1, 8'h02, 4'd2);
        repeat (5) step(1'b1, 8'h03, 4'd2);
        step(1'b0, 8'h00, 4'd0);
        check_val("gap_valid", v1[6:0], 7'b0110001);
        repeat (6) step(1'b0, 8'h00, 4'd0);
        check_val("gap_bits", h1[3:0], 4'b1011);

        // Zero-length word.
        zc = 0;
        step(1'b1, 8'hFF, 4'd0);
        repeat (3) step(1'b0, 8'h00, 4'd0);
        check_val("len0_quiet", zc, 0);

        // Over-long length clamps to WIDTH.
        h0 = '0; c0 = 0;
        step(1'b1, 8'hA5, 4'd12);
        repeat (10) step(1'b0, 8'h00, 4'd0);
        check_val("clamp_bits", h0[7:0], 8'hA5);
        check_val("clamp_cnt", c0, 8);

        // Reset mid-word.
        step(1'b1, 8'hFF, 4'd8);
        step(1'b0, 8'h00, 4'd0);
        reset = 1'b0;
        #1;
        check_val("rst_now0", {rdy0, av0, a0, wd0, bz0}, 5'b0);
        check_val("rst_now1", {rdy1, av1, a1, wd1, bz1}, 5'b0);
        model_reset();
        @(negedge clk);
        step(1'b0, 8'h00, 4'd0);
        reset = 1'b1;
        c0 = 0;
        repeat (6) step(1'b0, 8'h00, 4'd0);
        check_val("rst_nobits", c0, 0);

        // Random traffic.
        repeat (2000) begin
            step($urandom_range(0, 99) < 60, 8'($urandom), 4'($urandom_range(0, 12)));
        end
        repeat (12) step(1'b0, 8'h00, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
